// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: two-axis servo PWM generator.
//   Produces one pulse per frame on each axis. Pulse width is
//   BASE_TICKS + duty code ticks, clamped to FRAME_TICKS-1 ticks so every
//   frame has at least one low tick. Duty codes are captured into shadow
//   registers once per frame, so a duty change mid-frame never alters the
//   pulse already in progress.
// Ports:
//   Clk, Rst        clock, synchronous active-high reset
//   En              1 = run frames; 0 = outputs low, counters held at 0
//   Duty_X, Duty_Y  requested duty codes (unsigned, DUTY_W bits)
//   Pwm_X, Pwm_Y    registered servo pulses
//   Frame_Start     combinational strobe on the duty-sampling cycle
//   Duty_X_Act,
//   Duty_Y_Act      shadow duty codes in use for the current frame
module servo_pwm_gen #(
    parameter int unsigned DUTY_W      = 6,
    parameter int unsigned TICK_CYCLES = 781,
    parameter int unsigned FRAME_TICKS = 1280,
    parameter int unsigned BASE_TICKS  = 64
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              En,
    input  logic [DUTY_W-1:0] Duty_X,
    input  logic [DUTY_W-1:0] Duty_Y,
    output logic              Pwm_X,
    output logic              Pwm_Y,
    output logic              Frame_Start,
    output logic [DUTY_W-1:0] Duty_X_Act,
    output logic [DUTY_W-1:0] Duty_Y_Act
);

    localparam int unsigned PC_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned FC_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int unsigned LEN_W = DUTY_W + FC_W + 1;

    localparam logic [PC_W-1:0]  PC_MAX    = PC_W'(TICK_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_MAX    = FC_W'(FRAME_TICKS - 1);
    localparam logic [LEN_W-1:0] LEN_BASE  = LEN_W'(BASE_TICKS);
    localparam logic [LEN_W-1:0] LEN_CLAMP = LEN_W'(FRAME_TICKS - 1);

    logic [PC_W-1:0]  pc;
    logic [FC_W-1:0]  fc;
    logic [LEN_W-1:0] sum_x;
    logic [LEN_W-1:0] sum_y;
    logic [LEN_W-1:0] len_x;
    logic [LEN_W-1:0] len_y;
    logic [LEN_W-1:0] fc_ext;
    logic             pc_wrap;
    logic             frame_start;

    // Frame boundary detect and clamped pulse lengths from the shadows
    always_comb begin
        frame_start = En && !Rst && (pc == '0) && (fc == '0);
        pc_wrap     = (pc == PC_MAX);
        fc_ext      = LEN_W'(fc);
        sum_x       = LEN_BASE + LEN_W'(Duty_X_Act);
        sum_y       = LEN_BASE + LEN_W'(Duty_Y_Act);
        len_x       = (sum_x > LEN_CLAMP) ? LEN_CLAMP : sum_x;
        len_y       = (sum_y > LEN_CLAMP) ? LEN_CLAMP : sum_y;
    end

    assign Frame_Start = frame_start;

    // Prescaler, frame counter, duty shadows and pulse registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc         <= '0;
            fc         <= '0;
            Duty_X_Act <= '0;
            Duty_Y_Act <= '0;
            Pwm_X      <= 1'b0;
            Pwm_Y      <= 1'b0;
        end else if (!En) begin
            // Holding counters at 0 makes the first enabled cycle a frame start
            pc    <= '0;
            fc    <= '0;
            Pwm_X <= 1'b0;
            Pwm_Y <= 1'b0;
        end else begin
            pc <= pc_wrap ? '0 : pc + PC_W'(1);
            if (pc_wrap) begin
                fc <= (fc == FC_MAX) ? '0 : fc + FC_W'(1);
            end
            if (frame_start) begin
                Duty_X_Act <= Duty_X;
                Duty_Y_Act <= Duty_Y;
            end
            // fc==0 is below any length, so the stale shadow at the frame
            // start edge never affects the first pulse tick
            Pwm_X <= (fc_ext < len_x);
            Pwm_Y <= (fc_ext < len_y);
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen: directed bench for servo_pwm_gen.
//   Main instance: TICK_CYCLES=4, FRAME_TICKS=100, BASE_TICKS=10 (400 clk frame).
//   Clamp instance: FRAME_TICKS=50 (200 clk frame) to exercise length clamping.
module tb_servo_pwm_gen;

    localparam int unsigned DW    = 6;
    localparam int unsigned TICK  = 4;
    localparam int unsigned BASE  = 10;
    localparam int          FRAME = 400;
    localparam int          FRAME_C = 200;

    typedef struct {
        logic [DW-1:0] dx;
        logic [DW-1:0] dy;
        int            hx;
        int            hy;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] duty_x, duty_y;
    logic          pwm_x, pwm_y, fs;
    logic [DW-1:0] act_x, act_y;
    logic [DW-1:0] duty_cx, duty_cy;
    logic          pwm_cx, pwm_cy, fs_c;
    logic [DW-1:0] act_cx, act_cy;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    servo_pwm_gen #(.DUTY_W(DW), .TICK_CYCLES(TICK), .FRAME_TICKS(100), .BASE_TICKS(BASE)) dut (
        .Clk(clk), .Rst(rst), .En(en), .Duty_X(duty_x), .Duty_Y(duty_y),
        .Pwm_X(pwm_x), .Pwm_Y(pwm_y), .Frame_Start(fs),
        .Duty_X_Act(act_x), .Duty_Y_Act(act_y)
    );

    servo_pwm_gen #(.DUTY_W(DW), .TICK_CYCLES(TICK), .FRAME_TICKS(50), .BASE_TICKS(BASE)) dut_c (
        .Clk(clk), .Rst(rst), .En(en), .Duty_X(duty_cx), .Duty_Y(duty_cy),
        .Pwm_X(pwm_cx), .Pwm_Y(pwm_cy), .Frame_Start(fs_c),
        .Duty_X_Act(act_cx), .Duty_Y_Act(act_cy)
    );

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Step to the next negedge at which the main Frame_Start is high
    task automatic wait_fs(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (fs) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({name, "_fs_timeout"}, 0, 1);
    endtask

    // Called in a frame-start cycle; observes the following FRAME cycles.
    // chg_at > 0 drives Duty_X to chg_x at that cycle of the frame.
    task automatic measure(input int chg_at, input logic [DW-1:0] chg_x,
                           output int hx, output int hy,
                           output int first_x, output int first_y,
                           output int act_x1, output int act_y1,
                           output int act_x_end, output int fs_mid,
                           output int fs_end);
        hx = 0; hy = 0; fs_mid = 0;
        first_x = 0; first_y = 0; act_x1 = 0; act_y1 = 0; act_x_end = 0; fs_end = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (k == chg_at) duty_x = chg_x;
            if (k == 1) begin
                first_x = int'(pwm_x);
                first_y = int'(pwm_y);
                act_x1  = int'(act_x);
                act_y1  = int'(act_y);
            end
            if (k == FRAME - 1) act_x_end = int'(act_x);
            if (k < FRAME && fs) fs_mid++;
            if (k == FRAME) fs_end = int'(fs);
            hx += int'(pwm_x);
            hy += int'(pwm_y);
        end
    endtask

    task automatic check_frame(input string name, input int chg_at, input logic [DW-1:0] chg_x,
                               input int ex, input int ey, input int eax, input int eay,
                               input int eax_end);
        int hx, hy, fx, fy, ax, ay, axe, fm, fe;
        measure(chg_at, chg_x, hx, hy, fx, fy, ax, ay, axe, fm, fe);
        chk({name, "_high_x"}, hx, ex);
        chk({name, "_high_y"}, hy, ey);
        chk({name, "_rise_x"}, fx, 1);
        chk({name, "_rise_y"}, fy, 1);
        chk({name, "_act_x"}, ax, eax);
        chk({name, "_act_y"}, ay, eay);
        chk({name, "_act_x_end"}, axe, eax_end);
        chk({name, "_no_mid_fs"}, fm, 0);
        chk({name, "_period"}, fe, 1);
    endtask

    vec_t vecs[5];

    initial begin
        int hc, lowtail, fsc_ok;

        vecs[0] = '{dx: 6'd20, dy: 6'd5,  hx: 30*4, hy: 15*4};
        vecs[1] = '{dx: 6'd63, dy: 6'd63, hx: 73*4, hy: 73*4};
        vecs[2] = '{dx: 6'd0,  dy: 6'd63, hx: 10*4, hy: 73*4};
        vecs[3] = '{dx: 6'd1,  dy: 6'd2,  hx: 11*4, hy: 12*4};
        vecs[4] = '{dx: 6'd40, dy: 6'd17, hx: 50*4, hy: 27*4};

        rst = 1'b1; en = 1'b1;
        duty_x = 6'd5; duty_y = 6'd0;
        duty_cx = 6'd63; duty_cy = 6'd0;

        // Reset held for 3 clocks: everything low
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_pwm", int'({pwm_x, pwm_y, pwm_cx, pwm_cy}), 0);
            chk("rst_fs", int'({fs, fs_c}), 0);
            chk("rst_act", int'({act_x, act_y}), 0);
        end
        rst = 1'b0;
        #1;
        chk("rel_fs", int'(fs), 1);
        chk("rel_fs_c", int'(fs_c), 1);

        // First frame: Duty_X=5 -> 60 clks, Duty_Y=0 -> 40 clks
        check_frame("frame1", 0, 6'd0, 60, 40, 5, 0, 5);

        // Clamp instance: 63+10=73 clamps to 49 ticks -> 196 high, 4 low
        while (!fs_c) @(negedge clk);
        hc = 0; lowtail = 0; fsc_ok = 0;
        for (int k = 1; k <= FRAME_C; k++) begin
            @(negedge clk);
            hc += int'(pwm_cx);
            if (k > 196) lowtail += int'(!pwm_cx);
            if (k == FRAME_C) fsc_ok = int'(fs_c);
        end
        chk("clamp_high", hc, 196);
        chk("clamp_low_tail", lowtail, 4);
        chk("clamp_period", fsc_ok, 1);

        // Table vectors: new duties take effect at the next frame start
        foreach (vecs[i]) begin
            @(negedge clk);
            duty_x = vecs[i].dx;
            duty_y = vecs[i].dy;
            wait_fs($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), 0, 6'd0, vecs[i].hx, vecs[i].hy,
                        int'(vecs[i].dx), int'(vecs[i].dy), int'(vecs[i].dx));
        end

        // Mid-frame duty change: current frame unchanged, next frame updated
        @(negedge clk);
        duty_x = 6'd5; duty_y = 6'd0;
        wait_fs("midchg");
        check_frame("midchg_a", 20, 6'd20, 60, 40, 5, 0, 5);
        check_frame("midchg_b", 0, 6'd0, 120, 40, 20, 0, 20);

        // En falls at clk 30 of a pulse, low for a while, then rises
        duty_x = 6'd5;
        for (int k = 1; k <= 30; k++) @(negedge clk);
        chk("en_pre_pwm", int'(pwm_x), 1);
        en = 1'b0;
        @(negedge clk);
        chk("en_off_pwm", int'({pwm_x, pwm_y}), 0);
        hc = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            hc += int'(fs) + int'(pwm_x) + int'(pwm_y);
        end
        chk("en_off_quiet", hc, 0);
        chk("en_off_act_kept", int'(act_x), 5);
        duty_x = 6'd8;
        en = 1'b1;
        #1;
        chk("en_on_fs", int'(fs), 1);
        check_frame("en_on", 0, 6'd0, 72, 40, 8, 0, 8);

        // Reset mid-pulse: pulse and shadows drop on the next edge
        for (int k = 1; k <= 10; k++) @(negedge clk);
        chk("rst_mid_pre", int'(pwm_x), 1);
        rst = 1'b1;
        duty_x = 6'd0; duty_y = 6'd0;
        @(negedge clk);
        chk("rst_mid_pwm", int'({pwm_x, pwm_y}), 0);
        chk("rst_mid_act", int'({act_x, act_y}), 0);
        chk("rst_mid_fs", int'(fs), 0);
        rst = 1'b0;
        #1;
        chk("rst_rel_fs", int'(fs), 1);
        check_frame("rst_rel", 0, 6'd0, 40, 40, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
        $finish;
    end

endmodule
